// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the MEM/WB
// writeback and an attached IP block.
// - The pipeline has priority.
// - IP results wait in a small FIFO and drain in idle writeback slots.
// - A starvation guard forces one FIFO drain, stalling the pipeline for one
//   cycle, when the FIFO has gone ungranted for STARVE_MAX cycles.
// Optional feature: define WB_ARB_BYPASS_EN to write an IP result straight
// to the register file when the FIFO is empty and the pipeline is idle.
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pipe_wr_valid,
    input  logic [ADDR_W-1:0]          pipe_wr_addr,
    input  logic [DATA_W-1:0]          pipe_wr_data,
    input  logic                       ip_wr_valid,
    input  logic [ADDR_W-1:0]          ip_wr_addr,
    input  logic [DATA_W-1:0]          ip_wr_data,
    output logic                       ip_wr_ready,
    output logic                       pipe_stall,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [STV_W-1:0]    starve_q, starve_d;
    logic [ADDR_W-1:0]   addr_mem_q [DEPTH];
    logic [ADDR_W-1:0]   addr_mem_d [DEPTH];
    logic [DATA_W-1:0]   data_mem_q [DEPTH];
    logic [DATA_W-1:0]   data_mem_d [DEPTH];
    logic                rf_we_q, rf_we_d;
    logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;

    logic fifo_empty, fifo_full;
    logic ip_accept, ip_store, ip_enq;
    logic grant_pipe, grant_fifo, grant_byp;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == CNT_W'(DEPTH));
    // Readiness depends only on occupancy, never on a same-cycle drain.
    assign ip_wr_ready = !rst && !fifo_full;
    assign ip_accept   = ip_wr_valid && ip_wr_ready;
    // Writes to register 0 complete the handshake but are dropped.
    assign ip_store    = ip_accept && (ip_wr_addr != '0);

    assign pipe_stall = (state_q == ST_FORCE);
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign buf_count  = count_q;

    // Grant selection, FIFO/starvation bookkeeping and next-state logic.
    always_comb begin
        grant_pipe = 1'b0;
        grant_fifo = 1'b0;
        grant_byp  = 1'b0;
        state_d    = ST_NORMAL;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        starve_d   = starve_q;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        case (state_q)
            ST_NORMAL: begin
                if (pipe_wr_valid) begin
                    grant_pipe = 1'b1;
                end else if (!fifo_empty) begin
                    grant_fifo = 1'b1;
                end else begin
`ifdef WB_ARB_BYPASS_EN
                    grant_byp = ip_store;
`else
                    grant_byp = 1'b0;
`endif
                end
                // Forced drain once the head has waited STARVE_MAX cycles.
                if (!fifo_empty && !grant_fifo
                    && (starve_q == STV_W'(STARVE_MAX - 1))) begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                grant_fifo = !fifo_empty;
                state_d    = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase

        ip_enq = ip_store && !grant_byp;

        if (ip_enq) begin
            addr_mem_d[wr_ptr_q] = ip_wr_addr;
            data_mem_d[wr_ptr_q] = ip_wr_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (grant_fifo) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (ip_enq && !grant_fifo) begin
            count_d = count_q + CNT_W'(1);
        end else if (!ip_enq && grant_fifo) begin
            count_d = count_q - CNT_W'(1);
        end

        if (fifo_empty || grant_fifo) begin
            starve_d = '0;
        end else if (starve_q != STV_W'(STARVE_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end

        if (grant_pipe) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = pipe_wr_addr;
            rf_wdata_d = pipe_wr_data;
        end else if (grant_fifo) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = addr_mem_q[rd_ptr_q];
            rf_wdata_d = data_mem_q[rd_ptr_q];
        end else if (grant_byp) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ip_wr_addr;
            rf_wdata_d = ip_wr_data;
        end
    end

    // State, FIFO and write-port registers; reset discards buffered results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_NORMAL;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            starve_q   <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                addr_mem_q[i] <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            starve_q   <= starve_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a vector table for single-cycle
// behaviour, plus hand-written fill/starvation and mid-run reset sequences.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_wr_valid = 1'b0;
    logic [4:0]  pipe_wr_addr = '0;
    logic [31:0] pipe_wr_data = '0;
    logic        ip_wr_valid = 1'b0;
    logic [4:0]  ip_wr_addr = '0;
    logic [31:0] ip_wr_data = '0;
    logic        ip_wr_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  buf_count;

    int n_tests = 0;
    int n_fail  = 0;

    wb_port_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .pipe_wr_valid (pipe_wr_valid),
        .pipe_wr_addr  (pipe_wr_addr),
        .pipe_wr_data  (pipe_wr_data),
        .ip_wr_valid   (ip_wr_valid),
        .ip_wr_addr    (ip_wr_addr),
        .ip_wr_data    (ip_wr_data),
        .ip_wr_ready   (ip_wr_ready),
        .pipe_stall    (pipe_stall),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .buf_count     (buf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        iv;
        logic [4:0]  ia;
        logic [31:0] id;
        logic        e_ready;
        logic        e_stall;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                         input logic iv, input logic [4:0] ia, input logic [31:0] id);
        pipe_wr_valid = pv;
        pipe_wr_addr  = pa;
        pipe_wr_data  = pd;
        ip_wr_valid   = iv;
        ip_wr_addr    = ia;
        ip_wr_data    = id;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ready, input logic stall,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic [2:0] cnt);
        chk({tag, ".ready"}, 32'(ip_wr_ready), 32'(ready));
        chk({tag, ".stall"}, 32'(pipe_stall), 32'(stall));
        chk({tag, ".we"},    32'(rf_we), 32'(we));
        chk({tag, ".waddr"}, 32'(rf_waddr), 32'(wa));
        chk({tag, ".wdata"}, rf_wdata, wd);
        chk({tag, ".count"}, 32'(buf_count), 32'(cnt));
    endtask

    initial begin
        // Expected values are those seen just after the edge that consumes the inputs.
        vecs[0]  = '{1, 3,  32'hA5A5A5A5, 0, 0,  0,            1, 0, 1, 3,  32'hA5A5A5A5, 0};
        vecs[1]  = '{0, 0,  0,            0, 0,  0,            1, 0, 0, 3,  32'hA5A5A5A5, 0};
`ifdef WB_ARB_BYPASS_EN
        vecs[2]  = '{0, 0,  0,            1, 7,  32'h12345678, 1, 0, 1, 7,  32'h12345678, 0};
        vecs[3]  = '{0, 0,  0,            0, 0,  0,            1, 0, 0, 7,  32'h12345678, 0};
`else
        vecs[2]  = '{0, 0,  0,            1, 7,  32'h12345678, 1, 0, 0, 3,  32'hA5A5A5A5, 1};
        vecs[3]  = '{0, 0,  0,            0, 0,  0,            1, 0, 1, 7,  32'h12345678, 0};
`endif
        vecs[4]  = '{0, 0,  0,            0, 0,  0,            1, 0, 0, 7,  32'h12345678, 0};
        vecs[5]  = '{0, 0,  0,            1, 0,  32'hDEADBEEF, 1, 0, 0, 7,  32'h12345678, 0};
        vecs[6]  = '{0, 0,  0,            0, 0,  0,            1, 0, 0, 7,  32'h12345678, 0};
        vecs[7]  = '{1, 5,  32'h1111,     1, 9,  32'h2222,     1, 0, 1, 5,  32'h1111,     1};
        vecs[8]  = '{0, 0,  0,            0, 0,  0,            1, 0, 1, 9,  32'h2222,     0};
        vecs[9]  = '{1, 6,  32'h4444,     1, 10, 32'h5555,     1, 0, 1, 6,  32'h4444,     1};
        vecs[10] = '{1, 8,  32'h6666,     1, 11, 32'h7777,     1, 0, 1, 8,  32'h6666,     2};
        vecs[11] = '{0, 0,  0,            0, 0,  0,            1, 0, 1, 10, 32'h5555,     1};
        vecs[12] = '{0, 0,  0,            1, 12, 32'h8888,     1, 0, 1, 11, 32'h7777,     1};
        vecs[13] = '{0, 0,  0,            0, 0,  0,            1, 0, 1, 12, 32'h8888,     0};
        vecs[14] = '{0, 0,  0,            0, 0,  0,            1, 0, 0, 12, 32'h8888,     0};

        // Reset state while rst is held.
        #2;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        #20;
        rst = 1'b0;
        #1;
        chk("post_reset.ready", 32'(ip_wr_ready), 32'd1);

        // Table: pipe write, IP via FIFO, addr-0 drop, priority, simultaneous enq/deq.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].pv, vecs[i].pa, vecs[i].pd, vecs[i].iv, vecs[i].ia, vecs[i].id);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_we,
                    vecs[i].e_waddr, vecs[i].e_wdata, vecs[i].e_count);
        end

        // Fill: pipe busy every cycle, four IP writes accepted, fifth refused.
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h100 + 32'(k), 1, 5'(20 + k), 32'hC0000000 + 32'(k));
            step();
            chk_all($sformatf("fill%0d", k), (k != 3), 0, 1, 1, 32'h100 + 32'(k), 3'(k + 1));
        end
        drive(1, 1, 32'h104, 1, 24, 32'hC0000004);
        step();
        chk_all("fill_full", 0, 0, 1, 1, 32'h104, 4);
        ip_wr_valid = 1'b0;

        // Starvation: eighth ungranted cycle enters FORCE, next cycle drains head.
        for (int e = 6; e <= 10; e++) begin
            drive(1, 1, 32'h100 + 32'(e - 1), 0, 0, 0);
            step();
            if (e == 10)
                chk_all($sformatf("starve_e%0d", e), 1, 0, 1, 20, 32'hC0000000, 3);
            else
                chk_all($sformatf("starve_e%0d", e), 0, (e == 9), 1, 1, 32'h100 + 32'(e - 1), 4);
        end

        // Pattern repeats with a nine-cycle period.
        for (int j = 1; j <= 9; j++) begin
            drive(1, 1, 32'h200 + 32'(j), 0, 0, 0);
            step();
            if (j == 9)
                chk_all($sformatf("repeat_j%0d", j), 1, 0, 1, 21, 32'hC0000001, 2);
            else
                chk_all($sformatf("repeat_j%0d", j), 1, (j == 8), 1, 1, 32'h200 + 32'(j), 3);
        end

        // Mid-run reset: outputs clear asynchronously, buffered results are lost.
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_release.ready", 32'(ip_wr_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("after_rst%0d", k), 1, 0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
